// File: rtl/axis_latch_bank.sv
// axis_latch_bank: NUM_CH constant registers written over one AXI4-Stream slave.
// Writes addressed by TDEST land in shadow registers. An accepted TLAST beat
// commits every pending channel to the outputs in the same cycle.
// Optional build macro AXIS_LATCH_BANK_ERRCNT_EN adds err_count, a saturating
// counter of dropped out-of-range beats and of MODE=1 overwrites of unconsumed data.
module axis_latch_bank #(
  parameter int unsigned                   AXIS_TDATA_WIDTH = 32,
  parameter int unsigned                   NUM_CH           = 4,
  parameter int unsigned                   DEST_WIDTH       = 4,
  parameter int unsigned                   MODE             = 0,
  parameter logic [AXIS_TDATA_WIDTH-1:0]   RESET_VALUE      = '0
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0]        s_axis_tdata,
  input  logic [DEST_WIDTH-1:0]              s_axis_tdest,
  input  logic                               s_axis_tlast,
  input  logic                               s_axis_tvalid,
  output logic                               s_axis_tready,
  output logic [NUM_CH*AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic [NUM_CH-1:0]                  m_axis_tvalid,
  input  logic [NUM_CH-1:0]                  m_axis_tready,
`ifdef AXIS_LATCH_BANK_ERRCNT_EN
  output logic [15:0]                        err_count,
`endif
  output logic [NUM_CH-1:0]                  update_pulse
);

  localparam int unsigned W = AXIS_TDATA_WIDTH;

  logic [W-1:0]      shadow_q [NUM_CH];
  logic [W-1:0]      shadow_d [NUM_CH];
  logic [W-1:0]      data_q   [NUM_CH];
  logic [W-1:0]      data_d   [NUM_CH];
  logic [NUM_CH-1:0] dirty_q, dirty_d;
  logic [NUM_CH-1:0] valid_q, valid_d;
  logic [NUM_CH-1:0] pulse_q, pulse_d;
  logic [NUM_CH-1:0] wr_vec;
  logic [NUM_CH-1:0] commit_vec;
  logic              accept;
  logic              in_range;
  logic              commit;

  // No backpressure: the slave is ready whenever reset is released.
  assign s_axis_tready = aresetn;

  // Beat decode: which channel this beat writes and whether it commits.
  always_comb begin
    accept   = s_axis_tvalid & aresetn;
    in_range = (32'(s_axis_tdest) < NUM_CH);
    commit   = accept & s_axis_tlast;
    wr_vec   = '0;
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      wr_vec[ch] = accept & in_range & (32'(s_axis_tdest) == ch);
    end
    commit_vec = commit ? (dirty_q | wr_vec) : '0;
  end

  // Next state for shadows, outputs and per-channel flags; the beat being
  // committed bypasses its shadow so the last write always wins.
  always_comb begin
    dirty_d = commit ? '0 : (dirty_q | wr_vec);
    pulse_d = commit_vec;
    if (MODE == 1) begin
      valid_d = commit_vec | (valid_q & ~m_axis_tready);
    end else begin
      valid_d = commit_vec | valid_q;
    end
    for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
      shadow_d[ch] = wr_vec[ch] ? s_axis_tdata : shadow_q[ch];
      data_d[ch]   = data_q[ch];
      if (commit_vec[ch]) begin
        data_d[ch] = wr_vec[ch] ? s_axis_tdata : shadow_q[ch];
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      dirty_q <= '0;
      valid_q <= '0;
      pulse_q <= '0;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        shadow_q[ch] <= RESET_VALUE;
        data_q[ch]   <= RESET_VALUE;
      end
    end else begin
      dirty_q <= dirty_d;
      valid_q <= valid_d;
      pulse_q <= pulse_d;
      for (int unsigned ch = 0; ch < NUM_CH; ch++) begin
        shadow_q[ch] <= shadow_d[ch];
        data_q[ch]   <= data_d[ch];
      end
    end
  end

  // Flatten channel registers onto the master bus.
  for (genvar g = 0; g < int'(NUM_CH); g++) begin : g_out
    assign m_axis_tdata[g*W +: W] = data_q[g];
  end

  assign m_axis_tvalid = valid_q;
  assign update_pulse  = pulse_q;

`ifdef AXIS_LATCH_BANK_ERRCNT_EN
  logic [15:0] err_q, err_d;
  logic        err_evt;

  // One count per cycle with a dropped beat and/or an unconsumed overwrite.
  always_comb begin
    err_evt = accept & ~in_range;
    if (MODE == 1) begin
      err_evt = err_evt | (|(commit_vec & valid_q & ~m_axis_tready));
    end
    err_d = (err_evt && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
  end

  // Error counter register.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      err_q <= '0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_count = err_q;
`endif

endmodule
